pc_pipeline_unit: RTL and testbench



---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_stage_reg.sv | 29 ++
 rtl/pc_pipeline_unit.sv | 89 ++++++++
 tb/tb_pc_pipeline_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared PC-unit types and default constants.
// pc_stage_t is the unpacked view of one stage_pc/stage_valid slot.
package pc_pkg;
  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned PC_STEP  = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam pc_t PC_RESET_VECTOR = '0;

  typedef struct packed {
    pc_t  pc;
    logic valid;
  } pc_stage_t;

  function automatic pc_stage_t pc_stage_pack(input pc_t pc, input logic valid);
    pc_stage_t s;
    s.pc    = pc;
    s.valid = valid;
    return s;
  endfunction
endpackage

// File: rtl/pc_stage_reg.sv
// One tracked pipeline stage: PC plus valid bit.
// flush and bubble both drop the valid bit and keep the PC; hold freezes the stage.
module pc_stage_reg
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             hold,
  input  logic             bubble,
  input  logic             flush,
  input  logic [WIDTH-1:0] d_pc,
  input  logic             d_valid,
  output logic [WIDTH-1:0] pc,
  output logic             valid
);
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush || bubble) begin
      valid <= 1'b0;
    end else if (!hold) begin
      pc    <= d_pc;
      valid <= d_valid;
    end
  end
endmodule

// File: rtl/pc_pipeline_unit.sv
// Fetch PC register, next-PC mux, and per-stage PC/valid tracking.
// Priority: redirect > stall > sequential step.
module pc_pipeline_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter int unsigned      STEP         = PC_STEP,
  parameter int unsigned      ALIGN_BITS   = 2,
  parameter int unsigned      DEPTH        = 3,
  parameter int unsigned      FLUSH_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [WIDTH-1:0]       redirect_pc,
  input  logic                   err_clr,
  output logic [WIDTH-1:0]       pc_out,
  output logic [WIDTH-1:0]       pc_next,
  output logic [DEPTH*WIDTH-1:0] stage_pc,
  output logic [DEPTH-1:0]       stage_valid,
  output logic                   misalign_err
);
  // ALIGN_BITS=0 yields an all-zero mask, which disables both forcing and the check.
  localparam logic [WIDTH-1:0] ALIGN_MASK =
    WIDTH'((64'(1) << ALIGN_BITS) - 64'(1));

  logic [DEPTH-1:0][WIDTH-1:0] spc;
  logic [DEPTH-1:0]            sval;
  logic                        misaligned;

  assign misaligned = redirect && (|(redirect_pc & ALIGN_MASK));

  always_comb begin
    pc_next = pc_out + WIDTH'(STEP);
    if (redirect)   pc_next = redirect_pc & ~ALIGN_MASK;
    else if (stall) pc_next = pc_out;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) pc_out <= RESET_VECTOR;
    else      pc_out <= pc_next;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)            misalign_err <= 1'b0;
    else if (misaligned) misalign_err <= 1'b1;
    else if (err_clr)    misalign_err <= 1'b0;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    localparam bit IN_FLUSH = (k < FLUSH_STAGES);
    localparam bit IS_HEAD  = (k == 0);
    localparam bit IS_SLOT1 = (k == 1);

    logic [WIDTH-1:0] d_pc;
    logic             d_valid;
    logic             hold, bubble, flush;

    if (IS_HEAD) begin : g_head
      assign d_pc    = pc_out;
      assign d_valid = 1'b1;
    end else begin : g_body
      assign d_pc    = spc[k-1];
      assign d_valid = sval[k-1];
    end

    // Stall only shapes stages 0 and 1; a redirect overrides it everywhere.
    assign flush  = redirect && IN_FLUSH;
    assign hold   = !redirect && stall && IS_HEAD;
    assign bubble = !redirect && stall && IS_SLOT1;

    pc_stage_reg #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .clr     (clr),
      .hold    (hold),
      .bubble  (bubble),
      .flush   (flush),
      .d_pc    (d_pc),
      .d_valid (d_valid),
      .pc      (spc[k]),
      .valid   (sval[k])
    );
  end

  assign stage_pc    = spc;
  assign stage_valid = sval;
endmodule

// File: tb/tb_pc_pipeline_unit.sv
// Random + directed bench for pc_pipeline_unit against a stage-list reference model.
module tb_pc_pipeline_unit;
  import pc_pkg::*;

  localparam int D  = 3;
  localparam int FL = 2;

  logic        clk = 1'b0;
  logic        clr, stall, redirect, err_clr;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out, pc_next;
  logic [D*32-1:0] stage_pc;
  logic [D-1:0]    stage_valid;
  logic        misalign_err;

  logic        w_clr;
  logic        w_zero = 1'b0;
  logic [31:0] w_rpc = '0;
  logic [31:0] w_pc_out, w_pc_next;
  logic [D*32-1:0] w_stage_pc;
  logic [D-1:0]    w_stage_valid;
  logic        w_err;

  int n_vec = 0;
  int n_err = 0;

  pc_t       m_pc;
  pc_stage_t m_st[D];
  logic      m_err;

  always #5 clk = ~clk;

  pc_pipeline_unit dut (
    .clk(clk), .clr(clr), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .err_clr(err_clr), .pc_out(pc_out),
    .pc_next(pc_next), .stage_pc(stage_pc), .stage_valid(stage_valid),
    .misalign_err(misalign_err)
  );

  pc_pipeline_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .clr(w_clr), .stall(w_zero), .redirect(w_zero),
    .redirect_pc(w_rpc), .err_clr(w_zero), .pc_out(w_pc_out),
    .pc_next(w_pc_next), .stage_pc(w_stage_pc), .stage_valid(w_stage_valid),
    .misalign_err(w_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic pc_t exp_next();
    if (redirect) return redirect_pc & ~32'h3;
    if (stall)    return m_pc;
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc  = 32'h0;
    m_err = 1'b0;
    for (int k = 0; k < D; k++) m_st[k] = pc_stage_pack('0, 1'b0);
  endtask

  // Each stage takes its predecessor's old entry unless a flush/stall rule applies.
  task automatic model_edge();
    pc_stage_t old[D];
    for (int k = 0; k < D; k++) old[k] = m_st[k];
    for (int k = 0; k < D; k++) begin
      if (redirect && k < FL)            m_st[k].valid = 1'b0;
      else if (!redirect && stall && k == 0) m_st[k] = old[0];
      else if (!redirect && stall && k == 1) m_st[k].valid = 1'b0;
      else if (k == 0)                   m_st[0] = pc_stage_pack(m_pc, 1'b1);
      else                               m_st[k] = old[k-1];
    end
    if (redirect && redirect_pc[1:0] != 2'b00) m_err = 1'b1;
    else if (err_clr)                          m_err = 1'b0;
    m_pc = exp_next();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_out"}, pc_out, m_pc);
    for (int k = 0; k < D; k++) begin
      chk($sformatf("%s.spc%0d", tag, k), stage_pc[k*32 +: 32], m_st[k].pc);
      chk($sformatf("%s.sv%0d", tag, k), stage_valid[k], m_st[k].valid);
    end
    chk({tag, ".err"}, misalign_err, m_err);
  endtask

  task automatic step(input string tag, input logic s, input logic r,
                      input logic [31:0] rp, input logic ec);
    stall = s; redirect = r; redirect_pc = rp; err_clr = ec;
    #1;
    chk({tag, ".pc_next"}, pc_next, exp_next());
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".pc_out"}, pc_out, 32'h0);
    chk({tag, ".spc"}, stage_pc, '0);
    chk({tag, ".sv"}, stage_valid, '0);
    chk({tag, ".err"}, misalign_err, 1'b0);
  endtask

  initial begin
    clr = 1'b0; w_clr = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0; err_clr = 1'b0;
    model_reset();
    #2;
    check_reset("rst");
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;

    // Sequential fetch from reset
    for (int i = 0; i < 4; i++) step("seq", 1'b0, 1'b0, '0, 1'b0);
    chk("tp.pc10", pc_out, 32'h10);
    chk("tp.s0_c", stage_pc[31:0], 32'hC);
    chk("tp.s2_0", {stage_valid[2], stage_pc[95:64]}, {1'b1, 32'h4});

    // Stall two cycles then release
    step("stall", 1'b1, 1'b0, '0, 1'b0);
    step("stall", 1'b1, 1'b0, '0, 1'b0);
    chk("tp.stall_pc", pc_out, 32'h10);
    chk("tp.stall_s1v", stage_valid[1], 1'b0);
    step("rel", 1'b0, 1'b0, '0, 1'b0);
    chk("tp.rel_pc", pc_out, 32'h14);

    // Redirect overriding stall
    step("rd_st", 1'b1, 1'b1, 32'h200, 1'b0);
    chk("tp.rd_pc", pc_out, 32'h200);
    chk("tp.rd_v01", stage_valid[1:0], 2'b00);
    step("rd_nx", 1'b0, 1'b0, '0, 1'b0);
    chk("tp.rd_s0", {stage_valid[0], stage_pc[31:0]}, {1'b1, 32'h200});

    // Misaligned target, sticky flag, set-beats-clear
    step("mis", 1'b0, 1'b1, 32'h203, 1'b0);
    chk("tp.mis_pc", pc_out, 32'h200);
    chk("tp.mis_err", misalign_err, 1'b1);
    step("hold", 1'b0, 1'b0, '0, 1'b0);
    step("hold", 1'b1, 1'b0, '0, 1'b0);
    step("eclr", 1'b0, 1'b0, '0, 1'b1);
    chk("tp.eclr", misalign_err, 1'b0);
    step("mis2", 1'b0, 1'b1, 32'h203, 1'b0);
    step("setclr", 1'b0, 1'b1, 32'h101, 1'b1);
    chk("tp.setwin", misalign_err, 1'b1);
    step("rd_b2b", 1'b0, 1'b1, 32'h400, 1'b0);
    step("rd_b2b", 1'b0, 1'b1, 32'h800, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
           $urandom, ($urandom_range(0, 9) < 1));
    end

    // Async reset mid-cycle during a redirect
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h1234_5670; err_clr = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    model_reset();
    check_reset("arst");
    @(negedge clk);
    redirect = 1'b0; redirect_pc = '0;
    clr = 1'b1;
    step("post", 1'b0, 1'b0, '0, 1'b0);
    chk("tp.post_s0", {stage_valid[0], stage_pc[31:0]}, {1'b1, 32'h0});

    // Wrap-around through the alternate reset vector
    w_clr = 1'b1;
    @(posedge clk); #1;
    chk("wrap.0", w_pc_out, 32'hFFFF_FFFC);
    chk("wrap.s0", {w_stage_valid[0], w_stage_pc[31:0]}, {1'b1, 32'hFFFF_FFF8});
    @(posedge clk); #1;
    chk("wrap.1", w_pc_out, 32'h0);
    @(posedge clk); #1;
    chk("wrap.2", w_pc_out, 32'h4);
    chk("wrap.err", w_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
